// File: rtl/studio_keypad.sv
// Studio II keypad controller: PS/2 key events -> per-pad held bitmaps with minimum-hold stretching,
// CPU-programmable key select and registered active-low EF lines. Optional joystick input: STUDIO_KEYPAD_JOY_EN.
module studio_keypad #(
    parameter int              NUM_PADS    = 2,
    parameter int              HOLD_W      = 20,
    parameter logic [HOLD_W-1:0] HOLD_CYCLES = 20'd500000,
    parameter logic [2:0]      SEL_PORT    = 3'd2
) (
    input  logic                     clk,
    input  logic                     resetq,
    input  logic [10:0]              ps2_key,
    input  logic [2:0]               io_n,
    input  logic                     io_out,
    input  logic [7:0]               io_dout,
`ifdef STUDIO_KEYPAD_JOY_EN
    input  logic [NUM_PADS*10-1:0]   joy_keys,
`endif
    output logic [3:0]               key_sel,
    output logic [NUM_PADS*10-1:0]   key_state,
    output logic [NUM_PADS-1:0]      ef_n,
    output logic                     any_pressed
);

    localparam int NUM_KEYS = NUM_PADS * 10;

    logic                toggle_q;
    logic                armed;
    logic [NUM_KEYS-1:0] held;
    logic [NUM_KEYS-1:0] pend;
    logic [HOLD_W-1:0]   cnt [NUM_KEYS];
    logic [NUM_KEYS-1:0] press_vec;
    logic [NUM_KEYS-1:0] rel_vec;
    logic [NUM_KEYS-1:0] eff;
    logic [NUM_PADS-1:0] sel_hit;
    logic [5:0]          dec;

    wire unused_dout = &{1'b0, io_dout[7:4]};

    // Returns {valid, key index}; pad1 keys occupy indices 10..19.
    function automatic logic [5:0] decode_sc(input logic [7:0] sc);
        case (sc)
            8'h45: decode_sc = {1'b1, 5'd0};
            8'h16: decode_sc = {1'b1, 5'd1};
            8'h1E: decode_sc = {1'b1, 5'd2};
            8'h26: decode_sc = {1'b1, 5'd3};
            8'h25: decode_sc = {1'b1, 5'd4};
            8'h2E: decode_sc = {1'b1, 5'd5};
            8'h36: decode_sc = {1'b1, 5'd6};
            8'h3D: decode_sc = {1'b1, 5'd7};
            8'h3E: decode_sc = {1'b1, 5'd8};
            8'h46: decode_sc = {1'b1, 5'd9};
            8'h70: decode_sc = {1'b1, 5'd10};
            8'h69: decode_sc = {1'b1, 5'd11};
            8'h72: decode_sc = {1'b1, 5'd12};
            8'h7A: decode_sc = {1'b1, 5'd13};
            8'h6B: decode_sc = {1'b1, 5'd14};
            8'h73: decode_sc = {1'b1, 5'd15};
            8'h74: decode_sc = {1'b1, 5'd16};
            8'h6C: decode_sc = {1'b1, 5'd17};
            8'h75: decode_sc = {1'b1, 5'd18};
            8'h7D: decode_sc = {1'b1, 5'd19};
            default: decode_sc = 6'd0;
        endcase
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        dec       = decode_sc(ps2_key[7:0]);
        press_vec = '0;
        rel_vec   = '0;
        if (armed && (ps2_key[10] != toggle_q) && !ps2_key[8] && dec[5]) begin
            // Indices beyond NUM_KEYS (pad1 with a single pad) simply never match.
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (dec[4:0] == 5'(k)) begin
                    press_vec[k] = ps2_key[9];
                    rel_vec[k]   = ~ps2_key[9];
                end
            end
        end
    end

    // NOTE: state uses non-blocking assignments with an asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            toggle_q <= 1'b0;
            armed    <= 1'b0;
        end else begin
            toggle_q <= ps2_key[10];
            armed    <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            held <= '0;
            pend <= '0;
            // NOTE: the counter array is small flop storage, so it is reset explicitly to avoid a stale release after reset.
            for (int k = 0; k < NUM_KEYS; k++) cnt[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (press_vec[k]) begin
                    held[k] <= 1'b1;
                    cnt[k]  <= HOLD_CYCLES;
                    pend[k] <= 1'b0;
                end else begin
                    if (cnt[k] != '0) cnt[k] <= cnt[k] - 1'b1;
                    if (rel_vec[k]) begin
                        if (cnt[k] == '0) held[k] <= 1'b0;
                        else              pend[k] <= 1'b1;
                    end else if (pend[k] && cnt[k] == '0) begin
                        held[k] <= 1'b0;
                        pend[k] <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef STUDIO_KEYPAD_JOY_EN
    logic [NUM_KEYS-1:0] joy_s1, joy_s2;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            joy_s1 <= '0;
            joy_s2 <= '0;
        end else begin
            joy_s1 <= joy_keys;
            joy_s2 <= joy_s1;
        end
    end

    assign eff = held | joy_s2;
`else
    assign eff = held;
`endif

    assign key_state = eff;

    always_comb begin
        sel_hit = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            for (int k = 0; k < 10; k++) begin
                if (key_sel == 4'(k)) sel_hit[p] = eff[p*10 + k];
            end
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            key_sel     <= 4'd0;
            ef_n        <= '1;
            any_pressed <= 1'b0;
        end else begin
            if (io_out && io_n == SEL_PORT) key_sel <= io_dout[3:0];
            ef_n        <= ~sel_hit;
            any_pressed <= |eff;
        end
    end

endmodule

// File: tb/tb_studio_keypad.sv
// Self-checking bench for studio_keypad: directed sequences for hold/reset corners plus a select/event vector table.
module tb_studio_keypad;

    logic        clk;
    logic        resetq;
    logic [10:0] ps2_key;
    logic [2:0]  io_n;
    logic        io_out;
    logic [7:0]  io_dout;
    logic [3:0]  key_sel;
    logic [19:0] key_state;
    logic [1:0]  ef_n;
    logic        any_pressed;
`ifdef STUDIO_KEYPAD_JOY_EN
    logic [19:0] joy_keys = '0;
`endif

    int  n_cmp = 0;
    int  n_bad = 0;
    logic tog;
    int  cnt_set;

    typedef struct {
        logic        ev;
        logic [7:0]  sc;
        logic        pr;
        logic        ext;
        logic        wr;
        logic [2:0]  n;
        logic [7:0]  dout;
        logic [3:0]  e_sel;
        logic [1:0]  e_ef;
        logic [19:0] e_state;
    } vec_t;

    vec_t tbl [11];
    logic [7:0] pad0_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] pad1_codes [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

    studio_keypad #(
        .NUM_PADS   (2),
        .HOLD_W     (20),
        .HOLD_CYCLES(20'd8),
        .SEL_PORT   (3'd2)
    ) dut (
        .clk        (clk),
        .resetq     (resetq),
        .ps2_key    (ps2_key),
        .io_n       (io_n),
        .io_out     (io_out),
        .io_dout    (io_dout),
`ifdef STUDIO_KEYPAD_JOY_EN
        .joy_keys   (joy_keys),
`endif
        .key_sel    (key_sel),
        .key_state  (key_state),
        .ef_n       (ef_n),
        .any_pressed(any_pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_key(input logic [7:0] sc, input logic pr, input logic ext);
        tog     = ~tog;
        ps2_key = {tog, pr, ext, sc};
    endtask

    task automatic write_sel(input logic [2:0] n, input logic [7:0] d);
        io_out  = 1'b1;
        io_n    = n;
        io_dout = d;
        tick(1);
        io_out  = 1'b0;
    endtask

    initial begin
        //          ev    sc     pr    ext   wr    n     dout   sel   ef     state
        tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 8'h0C, 4'hC, 2'b11, 20'hFFFFF};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 8'h00, 4'h0, 2'b00, 20'hFFFFF};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 8'h09, 4'h9, 2'b00, 20'hFFFFF};
        tbl[3]  = '{1'b1, 8'h70, 1'b0, 1'b1, 1'b1, 3'd3, 8'h07, 4'h9, 2'b00, 20'hFFFFF};
        tbl[4]  = '{1'b1, 8'h3D, 1'b0, 1'b0, 1'b1, 3'd2, 8'h37, 4'h7, 2'b01, 20'hFFF7F};
        tbl[5]  = '{1'b1, 8'h72, 1'b0, 1'b0, 1'b0, 3'd2, 8'h00, 4'h7, 2'b01, 20'hFEF7F};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 8'h02, 4'h2, 2'b10, 20'hFEF7F};
        tbl[7]  = '{1'b1, 8'h1C, 1'b1, 1'b0, 1'b0, 3'd2, 8'h00, 4'h2, 2'b10, 20'hFEF7F};
        tbl[8]  = '{1'b1, 8'h72, 1'b1, 1'b0, 1'b0, 3'd2, 8'h00, 4'h2, 2'b00, 20'hFFF7F};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 8'h0F, 4'hF, 2'b11, 20'hFFF7F};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 8'h0A, 4'hA, 2'b11, 20'hFFF7F};

        tog     = 1'b1;
        ps2_key = 11'h400;
        io_n    = 3'd0;
        io_out  = 1'b0;
        io_dout = 8'h00;
        resetq  = 1'b0;
        tick(2);
        resetq  = 1'b1;
        tick(3);
        check("reset_key_state", key_state, 20'h0);
        check("reset_ef_n", ef_n, 2'b11);
        check("reset_key_sel", key_sel, 4'h0);
        check("reset_any", any_pressed, 1'b0);

        // Single press/release with stretching.
        write_sel(3'd2, 8'h05);
        check("sel_05", key_sel, 4'h5);
        send_key(8'h2E, 1'b1, 1'b0);
        tick(1);
        check("press_T1_state", key_state, 20'h00020);
        check("press_T1_ef", ef_n, 2'b11);
        tick(1);
        check("press_T2_ef", ef_n, 2'b10);
        check("press_T2_any", any_pressed, 1'b1);
        send_key(8'h2E, 1'b0, 1'b0);
        tick(1);
        cnt_set = 0;
        for (int i = 0; i < 7; i++) begin
            if (key_state[5]) cnt_set++;
            tick(1);
        end
        check("stretch_cycles_held", cnt_set, 7);
        check("stretch_T10_state", key_state, 20'h0);
        check("stretch_T10_ef", ef_n, 2'b10);
        tick(1);
        check("stretch_T11_ef", ef_n, 2'b11);
        check("stretch_T11_any", any_pressed, 1'b0);

        // Typematic repeat reloads the hold counter.
        send_key(8'h45, 1'b1, 1'b0);
        tick(5);
        send_key(8'h45, 1'b1, 1'b0);
        tick(2);
        send_key(8'h45, 1'b0, 1'b0);
        tick(7);
        check("repeat_T14_held", key_state[0], 1'b1);
        tick(1);
        check("repeat_T15_clear", key_state[0], 1'b0);

        // Press on the cycle the counter reaches zero with a release pending.
        send_key(8'h26, 1'b1, 1'b0);
        tick(2);
        send_key(8'h26, 1'b0, 1'b0);
        tick(7);
        send_key(8'h26, 1'b1, 1'b0);
        tick(1);
        check("presswin_T10", key_state[3], 1'b1);
        tick(12);
        check("presswin_T22", key_state[3], 1'b1);
        send_key(8'h26, 1'b0, 1'b0);
        tick(1);
        check("presswin_release", key_state, 20'h0);

        // Keys on both pads with select 1.
        write_sel(3'd2, 8'h01);
        send_key(8'h69, 1'b1, 1'b0);
        tick(1);
        send_key(8'h16, 1'b1, 1'b0);
        tick(2);
        check("two_pad_state", key_state, 20'h00802);
        check("two_pad_ef", ef_n, 2'b00);
        tick(10);
        send_key(8'h16, 1'b0, 1'b0);
        tick(2);
        check("pad0_rel_state", key_state, 20'h00800);
        check("pad0_rel_ef", ef_n, 2'b01);

        // Hold every key, then walk the vector table.
        for (int i = 0; i < 10; i++) begin
            send_key(pad0_codes[i], 1'b1, 1'b0);
            tick(1);
            send_key(pad1_codes[i], 1'b1, 1'b0);
            tick(1);
        end
        tick(12);
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].ev) send_key(tbl[i].sc, tbl[i].pr, tbl[i].ext);
            if (tbl[i].wr) begin
                io_out  = 1'b1;
                io_n    = tbl[i].n;
                io_dout = tbl[i].dout;
            end
            tick(1);
            io_out = 1'b0;
            tick(1);
            check($sformatf("vec%0d_sel", i), key_sel, tbl[i].e_sel);
            check($sformatf("vec%0d_ef", i), ef_n, tbl[i].e_ef);
            check($sformatf("vec%0d_state", i), key_state, tbl[i].e_state);
            check($sformatf("vec%0d_any", i), any_pressed, 1'b1);
        end

        // Reset while a release is pending.
        write_sel(3'd2, 8'h05);
        send_key(8'h2E, 1'b1, 1'b0);
        tick(2);
        send_key(8'h2E, 1'b0, 1'b0);
        tick(4);
        send_key(8'h2E, 1'b1, 1'b0);
        resetq = 1'b0;
        #1;
        check("rst_mid_state", key_state, 20'h0);
        check("rst_mid_ef", ef_n, 2'b11);
        check("rst_mid_sel", key_sel, 4'h0);
        check("rst_mid_any", any_pressed, 1'b0);
        tick(2);
        resetq = 1'b1;
        tick(20);
        check("post_rst_state", key_state, 20'h0);
        check("post_rst_ef", ef_n, 2'b11);
        check("post_rst_any", any_pressed, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
